// File: rtl/traffic_light_sequencer.sv
// Actuated two-direction traffic-light phase controller timed by the animation tick.
// Optional feature: define PREEMPT_EN to add the 2-bit preempt input (bit0 east-west, bit1 north-south).
module traffic_light_sequencer #(
    parameter int unsigned MIN_GREEN   = 3,
    parameter int unsigned MAX_GREEN   = 8,
    parameter int unsigned CLEAR_TICKS = 2
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       animateClk,
    input  logic       req_ew,
    input  logic       req_ns,
`ifdef PREEMPT_EN
    input  logic [1:0] preempt,
`endif
    output logic       traffic0_color,
    output logic       traffic1_color,
    output logic       traffic2_color,
    output logic       traffic3_color,
    output logic [1:0] phase,
    output logic       phase_strobe
);

    typedef enum logic [1:0] {
        EW_GREEN = 2'd0,
        EW_CLEAR = 2'd1,
        NS_GREEN = 2'd2,
        NS_CLEAR = 2'd3
    } state_t;

    localparam logic [7:0] MinG   = 8'(MIN_GREEN);
    localparam logic [7:0] MaxG   = 8'(MAX_GREEN);
    localparam logic [7:0] ClearT = 8'(CLEAR_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tick_q;
    logic       tickEdge;
    logic       preEw, preNs;

    assign tickEdge = animateClk & ~tick_q;

    // East-west preemption wins when both bits are set.
`ifdef PREEMPT_EN
    assign preEw = preempt[0];
    assign preNs = preempt[1] & ~preempt[0];
`else
    assign preEw = 1'b0;
    assign preNs = 1'b0;
`endif

    always_comb begin
        logic [7:0] n;
        state_d = state_q;
        cnt_d   = cnt_q;
        n       = cnt_q + 8'd1;
        if (tickEdge) begin
            case (state_q)
                EW_GREEN: begin
                    if (preEw) begin
                        cnt_d = cnt_q;
                    end else if (preNs || (n >= MaxG) ||
                                 ((n >= MinG) && req_ns && !req_ew)) begin
                        state_d = EW_CLEAR;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = n;
                    end
                end
                EW_CLEAR: begin
                    if (n >= ClearT) begin
                        state_d = preEw ? EW_GREEN : NS_GREEN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = n;
                    end
                end
                NS_GREEN: begin
                    if (preNs) begin
                        cnt_d = cnt_q;
                    end else if (preEw || (n >= MaxG) ||
                                 ((n >= MinG) && req_ew && !req_ns)) begin
                        state_d = NS_CLEAR;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = n;
                    end
                end
                default: begin
                    if (n >= ClearT) begin
                        state_d = preNs ? NS_GREEN : EW_GREEN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = n;
                    end
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they change on the same edge as the state register.
    always_ff @(posedge dclk) begin
        if (clr) begin
            state_q        <= NS_CLEAR;
            cnt_q          <= 8'd0;
            tick_q         <= 1'b0;
            traffic0_color <= 1'b0;
            traffic1_color <= 1'b0;
            traffic2_color <= 1'b0;
            traffic3_color <= 1'b0;
            phase          <= 2'd3;
            phase_strobe   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tick_q         <= animateClk;
            traffic0_color <= (state_d == EW_GREEN);
            traffic1_color <= (state_d == EW_GREEN);
            traffic2_color <= (state_d == NS_GREEN);
            traffic3_color <= (state_d == NS_GREEN);
            phase          <= state_d;
            phase_strobe   <= (state_d != state_q);
        end
    end

endmodule
